ifetch_ctrl: RTL
================

// Module: ifetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer in front of icache (16-bit Thumb halfwords, halfword-indexed).
//  Drives icache not_enable/index and keeps a small prefetch FIFO of {index,halfword} pairs.
//  Presents instructions to the decoder over a valid/ready handshake.
//  Handles branch redirect (flush) and halt; sits between icache and decode stage.
// PARAMETERS
//  RESET_PC    32'd0  halfword index fetched first after reset
//  FIFO_DEPTH  4      prefetch entries; power of 2, >=2
//  IDX_W       32     width of index / pc fields
// PORTS
//  clk                in   1      rising-edge clock
//  reset              in   1      synchronous, active-high
//  icache_not_enable  out  1      0 = icache reads icache_index this cycle
//  icache_index       out  IDX_W  halfword index to icache
//  icache_data        in   16     icache read data; valid the cycle after an issued read
//  instr_valid        out  1      FIFO head valid
//  instr_data         out  16     head halfword
//  instr_pc           out  IDX_W  head index
//  instr_ready        in   1      decoder accepts head when instr_valid&&instr_ready
//  redirect_valid     in   1      branch taken: flush and refetch from redirect_index
//  redirect_index     in   IDX_W  new fetch index
//  halt_req           in   1      stop issuing new reads (level)
//  fetch_idle         out  1      1 when state==HALT, nothing in flight, FIFO empty
// BEHAVIOUR
//  - Reset: state=BOOT, fetch_pc=RESET_PC, FIFO empty, inflight=0; icache_not_enable=1,
//    icache_index=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_idle=0.
//  - FSM: BOOT -> RUN unconditionally (one dead cycle). RUN -> HALT when halt_req.
//    HALT -> RUN on redirect_valid only. halt_req deasserting alone does not resume.
//  - Issue (combinational): in RUN, !halt_req, !redirect_valid, (count+inflight)<FIFO_DEPTH
//    -> icache_not_enable=0, icache_index=fetch_pc; fetch_pc<=fetch_pc+1 (wraps 2^32-1 -> 0).
//    Otherwise icache_not_enable=1, icache_index=fetch_pc.
//  - inflight<=issue; inflight_pc<=fetch_pc. When inflight, icache_data+inflight_pc pushed
//    into FIFO at end of that cycle. Credit rule guarantees no overflow; no pop credit taken.
//  - Pop on instr_valid&&instr_ready. Push and pop same cycle: count unchanged.
//  - Redirect (any state but BOOT, highest priority): FIFO cleared, inflight cleared (landing
//    data discarded), no issue that cycle, fetch_pc<=redirect_index, state<=RUN; a same-cycle
//    handshake is void (not a pop). Redirect in BOOT: latched, taking effect as above.
//  - Latency (no bypass): redirect @N, issue @N+1, data @N+2, instr_valid @N+3.
//    Steady state with instr_ready=1: one instruction per cycle.
//  - Empty: instr_valid=0, instr_data/instr_pc hold last value. Full: no issue.
//  - Halt: in-flight read still lands; FIFO keeps draining; fetch_idle when drained.
//  - reset mid-operation: everything returns to reset values at that edge, inflight dropped.
// CONFIGURATION
//  IFETCH_BYPASS_EN defined: when FIFO empty and inflight data arrives (not redirected),
//    instr_valid=1 same cycle with icache_data/inflight_pc; if accepted, not pushed.
//    Redirect-to-valid latency becomes N+2.
//  Not defined: all data goes through FIFO; latency as above; no icache_data->instr_* path.
// STRUCTURE
//  ifetch_defs.vh (`include): state encodings BOOT/RUN/HALT, IDX_W default, FIFO entry width.
//  Sub-module fetch_fifo: sync FIFO {pc,data}, push/pop/flush, count out; ptrs wrap mod DEPTH.
//  ifetch_ctrl: FSM, fetch_pc, inflight tracking, issue logic, optional bypass.
// TESTING
//  1 reset, RESET_PC=0x10, ready=1 -> issues 0x10,0x11,0x12 on cycles 1,2,3; first valid
//    pc=0x10 on cycle 3 (cycle 2 with bypass), then one per cycle in order.
//  2 ready=0 for 10 cycles -> exactly FIFO_DEPTH entries held, not_enable=1; ready=1 drains
//    0x10..0x13 in order, no loss or duplicate.
//  3 redirect_valid=1 index=0x200 while FIFO full and read inflight -> next cycle valid=0,
//    old data never appears; next instr_pc=0x200 at N+3.
//  4 redirect index=0xFFFFFFFE, ready=1 -> pcs 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
//  5 halt_req=1 mid-stream -> no further issue, inflight entry delivered, fetch_idle=1 after
//    drain; drop halt_req -> stays HALT; redirect 0x40 -> resumes from 0x40.
//  6 reset asserted with FIFO half full and redirect same cycle -> next cycle all outputs at
//    reset values, fetch resumes from RESET_PC.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the fetch FSM encoding and the width of a prefetch entry.
package ifetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int DATA_W        = 16;
    localparam int IDX_W_DEFAULT = 32;

    // A prefetch entry is {halfword index, halfword data}.
    function automatic int entry_width(input int idx_w);
        return idx_w + DATA_W;
    endfunction

endpackage

// File: rtl/ifetch_ctrl_fetch_fifo.sv
// Synchronous prefetch FIFO of {pc,data} entries with push/pop/flush.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module ifetch_ctrl_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_entry,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer between icache and decode: issue, prefetch, redirect, halt.
// Define IFETCH_BYPASS_EN to let landing icache data reach the decoder while the FIFO is empty.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int               IDX_W      = IDX_W_DEFAULT,
    parameter logic [IDX_W-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              icache_not_enable,
    output logic [IDX_W-1:0]  icache_index,
    input  logic [15:0]       icache_data,
    output logic              instr_valid,
    output logic [15:0]       instr_data,
    output logic [IDX_W-1:0]  instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [IDX_W-1:0]  redirect_index,
    input  logic              halt_req,
    output logic              fetch_idle
);

    localparam int ENTRY_W = entry_width(IDX_W);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state;
    logic [IDX_W-1:0]   fetch_pc;
    logic [IDX_W-1:0]   inflight_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_entry;
    logic [15:0]        last_data;
    logic [IDX_W-1:0]   last_pc;
    logic               fifo_empty;
    logic               issue;
    logic               push;
    logic               pop;

    ifetch_ctrl_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    // Reads in flight count against FIFO space so a landing halfword always has a slot.
    always_comb begin
        fifo_empty        = (count == '0);
        occupancy         = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue             = (state == ST_RUN) && !halt_req && !redirect_valid
                            && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        icache_not_enable = !issue;
        icache_index      = fetch_pc;
        push_entry        = {inflight_pc, icache_data};
        fetch_idle        = (state == ST_HALT) && !inflight && fifo_empty;
    end

`ifdef IFETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass      = fifo_empty && inflight && !redirect_valid;
        instr_valid = !fifo_empty || bypass;
        if (!fifo_empty) begin
            instr_data = head[15:0];
            instr_pc   = head[ENTRY_W-1:16];
        end else if (bypass) begin
            instr_data = icache_data;
            instr_pc   = inflight_pc;
        end else begin
            instr_data = last_data;
            instr_pc   = last_pc;
        end
        push = inflight && !redirect_valid && !(bypass && instr_ready);
        pop  = !fifo_empty && instr_ready && !redirect_valid;
    end
`else
    always_comb begin
        instr_valid = !fifo_empty;
        instr_data  = fifo_empty ? last_data : head[15:0];
        instr_pc    = fifo_empty ? last_pc   : head[ENTRY_W-1:16];
        push        = inflight && !redirect_valid;
        pop         = !fifo_empty && instr_ready && !redirect_valid;
    end
`endif

    // Remember the last presented instruction so the outputs hold while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= '0;
            last_pc   <= '0;
        end else if (instr_valid) begin
            last_data <= instr_data;
            last_pc   <= instr_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= issue;
            inflight_pc <= fetch_pc;
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    if (redirect_valid) begin
                        fetch_pc <= redirect_index;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_index;
                    end else begin
                        if (halt_req) begin
                            state <= ST_HALT;
                        end
                        if (issue) begin
                            fetch_pc <= fetch_pc + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        state    <= ST_RUN;
                        fetch_pc <= redirect_index;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
